panel_event_queue: RTL

//  Queues front-panel rotary-encoder events (rotation click, direction, push switch) between the encoder

---
 rtl/panel_pkg.sv | 33 +++
 rtl/panel_event_queue_if.sv | 29 ++
 rtl/panel_evt_fifo.sv | 51 +++++
 rtl/panel_event_queue.sv | 100 ++++++++++
 4 files changed

// File: rtl/panel_pkg.sv
// Shared types and constants for the front-panel event queue.
// Entry width depends on PANEL_COALESCE_EN (repeat field stored only when coalescing).
package panel_pkg;

  localparam int PANEL_EVT_W = 8;

  localparam int EVT_CLICK  = 0;
  localparam int EVT_CW     = 1;
  localparam int EVT_SW     = 2;
  localparam int EVT_VALID  = 3;
  localparam int EVT_OVF    = 4;
  localparam int EVT_REPEAT = 5;

  localparam int          RPT_W   = 3;
  localparam logic [2:0]  RPT_MAX = 3'd7;

  // 'repeat' is a keyword, so the field is named rpt
  typedef struct packed {
    logic [2:0] rpt;
    logic       ovf;
    logic       valid;
    logic       sw;
    logic       cw;
    logic       click;
  } panel_evt_t;

`ifdef PANEL_COALESCE_EN
  localparam int ENTRY_W = 6;
`else
  localparam int ENTRY_W = 3;
`endif

endpackage

// File: rtl/panel_event_queue_if.sv
// Encoder-side and CPU-side signals of the panel event queue.
// Handshake: evt_stb, rd_stb and clr_drops are single-cycle strobes with no back-pressure; rd_data is valid the cycle after rd_stb.
interface panel_event_queue_if #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
);
  localparam int AW = $clog2(DEPTH);

  logic              evt_stb;
  logic              evt_click;
  logic              evt_clockwise;
  logic              evt_switch;
  logic              rd_stb;
  logic              clr_drops;
  logic [7:0]        rd_data;
  logic [AW:0]       level;
  logic              irq;
  logic [DROP_W-1:0] drop_count;

  modport master (
    output evt_stb, evt_click, evt_clockwise, evt_switch, rd_stb, clr_drops,
    input  rd_data, level, irq, drop_count
  );

  modport slave (
    input  evt_stb, evt_click, evt_clockwise, evt_switch, rd_stb, clr_drops,
    output rd_data, level, irq, drop_count
  );
endinterface

// File: rtl/panel_evt_fifo.sv
// Circular event store with level tracking and a write port onto the newest entry (tail merge).
// Storage is deliberately not reset; only pointers and level are.
module panel_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 3,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  input  logic          i_tail_wr,
  input  logic [DW-1:0] i_tail_data,
  output logic [DW-1:0] o_head,
  output logic [DW-1:0] o_tail,
  output logic [AW:0]   o_level,
  output logic [AW:0]   o_level_next
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [AW-1:0] w_tail_ptr;

  assign w_tail_ptr   = r_wr_ptr - 1'b1;
  assign o_head       = r_mem[r_rd_ptr];
  assign o_tail       = r_mem[w_tail_ptr];
  assign o_level      = r_level;
  assign o_level_next = r_level + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};

  // Push and tail merge are mutually exclusive by construction in the caller
  always_ff @(posedge clk) begin
    if (i_push)    r_mem[r_wr_ptr]   <= i_push_data;
    if (i_tail_wr) r_mem[w_tail_ptr] <= i_tail_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= o_level_next;
    end
  end

endmodule

// File: rtl/panel_event_queue.sv
// Front-panel encoder event queue: push/merge/drop decision, sticky overflow, drop counter, CPU read word and irq.
// Optional click coalescing is built when PANEL_COALESCE_EN is defined.
module panel_event_queue
  import panel_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  panel_event_queue_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] w_head, w_tail, w_push_data, w_tail_data;
  logic [AW:0]        w_level, w_level_next;
  logic               w_full, w_empty, w_pop, w_push, w_merge, w_drop;
  logic [2:0]         w_head_rpt;

  logic [7:0]         r_rd_data;
  logic               r_irq;
  logic               r_ovf;
  logic [DROP_W-1:0]  r_drop_count;
  panel_evt_t         w_rd_word;

  assign w_full  = (w_level == (AW+1)'(DEPTH));
  assign w_empty = (w_level == '0);
  assign w_pop   = bus.rd_stb && !w_empty;

`ifdef PANEL_COALESCE_EN
  // Never merge into the single entry being popped this cycle
  assign w_merge = bus.evt_stb && bus.evt_click && !w_empty &&
                   !(w_pop && w_level == (AW+1)'(1)) &&
                   w_tail[EVT_CLICK] && (w_tail[EVT_CW] == bus.evt_clockwise) &&
                   (w_tail[EVT_SW] == bus.evt_switch) && (w_tail[5:3] != RPT_MAX);
  assign w_push_data = {3'b000, bus.evt_switch, bus.evt_clockwise, bus.evt_click};
  assign w_tail_data = {w_tail[5:3] + 3'd1, w_tail[2:0]};
  assign w_head_rpt  = w_head[5:3];
`else
  assign w_merge     = 1'b0;
  assign w_push_data = {bus.evt_switch, bus.evt_clockwise, bus.evt_click};
  assign w_tail_data = w_tail;
  assign w_head_rpt  = 3'b000;
`endif

  assign w_push = bus.evt_stb && !w_merge && (!w_full || w_pop);
  assign w_drop = bus.evt_stb && !w_merge && w_full && !w_pop;

  panel_evt_fifo #(.DEPTH(DEPTH), .DW(ENTRY_W)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_data  (w_push_data),
    .i_pop        (w_pop),
    .i_tail_wr    (w_merge),
    .i_tail_data  (w_tail_data),
    .o_head       (w_head),
    .o_tail       (w_tail),
    .o_level      (w_level),
    .o_level_next (w_level_next)
  );

  always_comb begin
    w_rd_word       = '0;
    w_rd_word.ovf   = r_ovf;
    if (w_pop) begin
      w_rd_word.rpt   = w_head_rpt;
      w_rd_word.valid = 1'b1;
      w_rd_word.sw    = w_head[EVT_SW];
      w_rd_word.cw    = w_head[EVT_CW];
      w_rd_word.click = w_head[EVT_CLICK];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data    <= '0;
      r_irq        <= 1'b0;
      r_ovf        <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_irq <= (w_level_next != '0);
      if (bus.rd_stb) r_rd_data <= w_rd_word;
      // A drop in the same cycle as a read keeps the flag for the next read
      if (w_drop)          r_ovf <= 1'b1;
      else if (bus.rd_stb) r_ovf <= 1'b0;
      if (bus.clr_drops)
        r_drop_count <= {{(DROP_W-1){1'b0}}, w_drop};
      else if (w_drop && r_drop_count != '1)
        r_drop_count <= r_drop_count + 1'b1;
    end
  end

  assign bus.rd_data    = r_rd_data;
  assign bus.level      = w_level;
  assign bus.irq        = r_irq;
  assign bus.drop_count = r_drop_count;

endmodule
